// File: rtl/syn_current_integrator.sv
// Synaptic weight store plus integration engine. Holds NUM_SYN float32 weights written by the
// STDP learner and, on START, sums the weights of the latched spiking synapses one per cycle
// through a single shared float32 adder. The result is presented as I_SYN.
module syn_current_integrator #(
    parameter int unsigned NUM_SYN = 10,
    parameter int unsigned ADDR_W  = 4,
    parameter int unsigned W       = 32
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               we_i,
    input  logic [ADDR_W-1:0]  waddr_i,
    input  logic [W-1:0]       wdata_i,
    input  logic               start_i,
    input  logic [NUM_SYN-1:0] pre_spikes_i,
    output logic               busy_o,
    output logic               done_o,
    output logic [W-1:0]       i_syn_o
);

    typedef enum logic [0:0] {StIdle, StScan} state_e;

    localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(NUM_SYN - 1);

    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  idx_q, idx_d;
    logic [W-1:0]       acc_q, acc_d;
    logic [NUM_SYN-1:0] spike_q, spike_d;
    logic [W-1:0]       isyn_q, isyn_d;
    logic               done_q, done_d;
    logic [W-1:0]       mem_q [NUM_SYN];

    logic [W-1:0] add_a, add_b, add_y;

    // Leading-zero count over the 27-bit aligned mantissa (hidden bit at position 26).
    function automatic logic [4:0] lzc27(input logic [26:0] v);
        logic [4:0] cnt;
        logic       found;
        cnt   = 5'd27;
        found = 1'b0;
        for (int i = 26; i >= 0; i--) begin
            if (!found && v[i]) begin
                cnt   = 5'(26 - i);
                found = 1'b1;
            end
        end
        return cnt;
    endfunction

    // Weight memory: writes accepted in every state, out-of-range addresses dropped.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int k = 0; k < NUM_SYN; k++) mem_q[k] <= '0;
        end else if (we_i && (32'(waddr_i) < NUM_SYN)) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign add_a = acc_q;
    assign add_b = mem_q[idx_q];

    logic        a_nan, b_nan, a_inf, b_inf, swap, eff_sub, sticky, rnd;
    logic [31:0] big, sml;
    logic [9:0]  e_big, e_sml, d, e_m1, e_n, e_f;
    logic [4:0]  dsh, lz, sh;
    logic [26:0] m_big, m_sml, m_sh, m_al, n;
    logic [27:0] sum;
    logic [23:0] mant;
    logic [24:0] mant_r;
    logic [22:0] frac;

    // Float32 adder, round-to-nearest-even with subnormals; NaN and Inf operands pass through.
    always_comb begin
        a_nan   = (add_a[30:23] == 8'hFF) && (add_a[22:0] != '0);
        b_nan   = (add_b[30:23] == 8'hFF) && (add_b[22:0] != '0);
        a_inf   = (add_a[30:23] == 8'hFF) && (add_a[22:0] == '0);
        b_inf   = (add_b[30:23] == 8'hFF) && (add_b[22:0] == '0);
        swap    = add_b[30:0] > add_a[30:0];
        big     = swap ? add_b : add_a;
        sml     = swap ? add_a : add_b;
        e_big   = (big[30:23] == 8'h00) ? 10'd1 : {2'b00, big[30:23]};
        e_sml   = (sml[30:23] == 8'h00) ? 10'd1 : {2'b00, sml[30:23]};
        m_big   = {big[30:23] != 8'h00, big[22:0], 3'b000};
        m_sml   = {sml[30:23] != 8'h00, sml[22:0], 3'b000};
        d       = e_big - e_sml;
        dsh     = (d > 10'd27) ? 5'd27 : d[4:0];
        m_sh    = m_sml >> dsh;
        sticky  = ((m_sh << dsh) != m_sml);
        m_al    = {m_sh[26:1], m_sh[0] | sticky};
        eff_sub = big[31] ^ sml[31];
        sum     = eff_sub ? ({1'b0, m_big} - {1'b0, m_al}) : ({1'b0, m_big} + {1'b0, m_al});
        lz      = lzc27(sum[26:0]);
        e_m1    = e_big - 10'd1;
        sh      = 5'd0;
        // Carry-out renormalises right; otherwise shift left but never below the subnormal exponent.
        if (sum[27]) begin
            n   = {sum[27:2], sum[1] | sum[0]};
            e_n = e_big + 10'd1;
        end else begin
            sh  = (e_m1 < {5'd0, lz}) ? e_m1[4:0] : lz;
            n   = sum[26:0] << sh;
            e_n = e_big - {5'd0, sh};
        end
        mant   = n[26:3];
        rnd    = n[2] & (n[1] | n[0] | n[3]);
        mant_r = {1'b0, mant} + 25'(rnd);
        if (mant_r[24]) begin
            e_f  = e_n + 10'd1;
            frac = mant_r[23:1];
        end else if (mant_r[23]) begin
            e_f  = e_n;
            frac = mant_r[22:0];
        end else begin
            e_f  = 10'd0;
            frac = mant_r[22:0];
        end

        if (a_nan) begin
            add_y = add_a;
        end else if (b_nan) begin
            add_y = add_b;
        end else if (a_inf && b_inf && (add_a[31] != add_b[31])) begin
            add_y = 32'h7FC0_0000;
        end else if (a_inf) begin
            add_y = add_a;
        end else if (b_inf) begin
            add_y = add_b;
        end else if (sum == '0) begin
            // Exact zero is +0 unless both operands were -0.
            add_y = {~eff_sub & big[31], 31'd0};
        end else if (e_f >= 10'd255) begin
            add_y = {big[31], 8'hFF, 23'd0};
        end else begin
            add_y = {big[31], e_f[7:0], frac};
        end
    end

    // State register and datapath registers, synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            idx_q   <= '0;
            acc_q   <= '0;
            spike_q <= '0;
            isyn_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
            spike_q <= spike_d;
            isyn_q  <= isyn_d;
            done_q  <= done_d;
        end
    end

    // Next-state: latch spikes on START, then walk one synapse per cycle.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        acc_d   = acc_q;
        spike_d = spike_q;
        isyn_d  = isyn_q;
        done_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    spike_d = pre_spikes_i;
                    idx_d   = '0;
                    acc_d   = '0;
                    state_d = StScan;
                end
            end
            StScan: begin
                if (spike_q[idx_q]) acc_d = add_y;
                idx_d = idx_q + 1'b1;
                if (idx_q == LastIdx) begin
                    isyn_d  = spike_q[idx_q] ? add_y : acc_q;
                    done_d  = 1'b1;
                    idx_d   = '0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs: BUSY tracks the scan state, DONE and I_SYN are registered.
    always_comb begin
        busy_o  = (state_q == StScan);
        done_o  = done_q;
        i_syn_o = isyn_q;
    end

endmodule

// File: tb/tb_syn_current_integrator.sv
// Randomised and directed bench for syn_current_integrator; weights are quarter-integers so
// every partial sum is exact in float32 and the reference can use plain real arithmetic.
module tb_syn_current_integrator;

    localparam int NS = 10;

    logic          clk = 1'b0;
    logic          rst, we, start;
    logic [3:0]    waddr;
    logic [31:0]   wdata;
    logic [NS-1:0] pre;
    logic          busy, done;
    logic [31:0]   isyn;

    logic [31:0] model [NS];
    int n_cmp = 0;
    int n_bad = 0;

    syn_current_integrator #(.NUM_SYN(NS), .ADDR_W(4), .W(32)) dut (
        .clk_i(clk), .rst_i(rst), .we_i(we), .waddr_i(waddr), .wdata_i(wdata),
        .start_i(start), .pre_spikes_i(pre), .busy_o(busy), .done_o(done), .i_syn_o(isyn)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic real f2r(input logic [31:0] b);
        logic [63:0] d;
        if (b[30:0] == '0) return 0.0;
        d = {b[31], 11'(b[30:23]) + 11'd896, b[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] r2f(input real r);
        logic [63:0] d;
        logic [10:0] e;
        if (r == 0.0) return 32'h0;
        d = $realtobits(r);
        e = d[62:52] - 11'd896;
        return {d[63], e[7:0], d[51:29]};
    endfunction

    function automatic logic [31:0] qw(input int k);
        return r2f(real'(k) / 4.0);
    endfunction

    task automatic clear_model();
        for (int k = 0; k < NS; k++) model[k] = 32'h0;
    endtask

    task automatic wr(input int addr, input logic [31:0] data);
        we = 1'b1; waddr = 4'(addr); wdata = data;
        tick();
        we = 1'b0;
        if (addr < NS) model[addr] = data;
    endtask

    // One pass: optional write at scan step coll_at and optional extra START pulse at restart_at.
    task automatic run_pass(input string tag, input logic [NS-1:0] spikes, input bit use_model,
                            input int coll_at, input int coll_addr, input logic [31:0] coll_data,
                            input int restart_at, output logic [31:0] got);
        real r;
        logic [31:0] w;
        int n, busy_cnt;
        r = 0.0;
        for (int k = 0; k < NS; k++) begin
            w = model[k];
            // A write lands in time only for synapses the scan has not reached yet.
            if (coll_at >= 0 && coll_addr == k && k > coll_at) w = coll_data;
            if (spikes[k]) r += f2r(w);
        end
        start = 1'b1; pre = spikes;
        tick();
        start = 1'b0; pre = NS'($urandom);
        busy_cnt = int'(busy);
        n = 0;
        while (!done && n < 3 * NS) begin
            if (n == coll_at) begin we = 1'b1; waddr = 4'(coll_addr); wdata = coll_data; end
            if (n == restart_at) start = 1'b1;
            tick();
            we = 1'b0; start = 1'b0;
            n++;
            if (!done) busy_cnt += int'(busy);
        end
        chk({tag, " latency"}, 32'(n), 32'(NS));
        chk({tag, " busy_cycles"}, 32'(busy_cnt), 32'(NS));
        chk({tag, " busy_at_done"}, 32'(busy), 32'h0);
        if (use_model) chk({tag, " i_syn"}, isyn, r2f(r));
        got = isyn;
        if (coll_at >= 0 && coll_at < NS && coll_addr < NS) model[coll_addr] = coll_data;
        tick();
        chk({tag, " done_one_cycle"}, 32'(done), 32'h0);
    endtask

    task automatic count_dones(input int cycles, output int cnt);
        cnt = 0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            if (done) cnt++;
        end
    endtask

    initial begin
        logic [31:0] got;
        int cnt, nw, ca;
        int dpos [3];

        rst = 1'b1; we = 1'b0; start = 1'b0; waddr = '0; wdata = '0; pre = '0;
        clear_model();
        tick(); tick();
        rst = 1'b0;
        chk("reset busy", 32'(busy), 32'h0);
        chk("reset done", 32'(done), 32'h0);
        chk("reset i_syn", isyn, 32'h0);

        // Empty memory integrates to +0.
        run_pass("t1", '1, 1'b1, -1, 0, 0, -1, got);
        chk("t1 const", got, 32'h0);

        wr(0, 32'h3F80_0000); wr(3, 32'h4000_0000); wr(9, 32'hBF00_0000);
        run_pass("t2a", 10'b1000001001, 1'b1, -1, 0, 0, -1, got);
        chk("t2a const", got, 32'h4020_0000);
        run_pass("t2b", 10'b0000001000, 1'b1, -1, 0, 0, -1, got);
        chk("t2b const", got, 32'h4000_0000);
        run_pass("t2c", 10'b0, 1'b1, -1, 0, 0, -1, got);
        chk("t2c const", got, 32'h0);

        // Write to the synapse being read in that very cycle only affects later passes.
        run_pass("t3a", 10'b1000001001, 1'b1, 3, 3, 32'h4040_0000, -1, got);
        chk("t3a const", got, 32'h4020_0000);
        run_pass("t3b", 10'b1000001001, 1'b1, -1, 0, 0, -1, got);
        chk("t3b const", got, 32'h4060_0000);
        wr(12, 32'h4120_0000);
        run_pass("t3c", 10'b1000001001, 1'b1, -1, 0, 0, -1, got);
        chk("t3c const", got, 32'h4060_0000);

        // START while busy is dropped.
        run_pass("t4a", 10'b1000001001, 1'b1, -1, 0, 0, 3, got);
        count_dones(15, cnt);
        chk("t4a no_extra_done", 32'(cnt), 32'h0);

        // START held high: back-to-back passes every NS+1 cycles.
        start = 1'b1; pre = 10'b1000001001;
        tick();
        cnt = 0;
        for (int c = 1; c <= 40; c++) begin
            tick();
            if (c == 29) start = 1'b0;
            if (done) begin
                if (cnt < 3) dpos[cnt] = c;
                cnt++;
            end
            if (c >= NS) chk("t4b i_syn_stable", isyn, 32'h4060_0000);
        end
        chk("t4b done_count", 32'(cnt), 32'd3);
        chk("t4b done0", 32'(dpos[0]), 32'd10);
        chk("t4b done1", 32'(dpos[1]), 32'd21);
        chk("t4b done2", 32'(dpos[2]), 32'd32);

        // NaN and Inf weights pass straight through the adder.
        wr(1, 32'h7FC0_0000);
        run_pass("nan", 10'b0000000011, 1'b0, -1, 0, 0, -1, got);
        chk("nan const", got, 32'h7FC0_0000);
        wr(1, 32'h7F80_0000);
        run_pass("inf", 10'b0000000011, 1'b0, -1, 0, 0, -1, got);
        chk("inf const", got, 32'h7F80_0000);
        wr(1, 32'h0);

        // Randomised passes against the arithmetic model.
        for (int it = 0; it < 30; it++) begin
            nw = int'($urandom_range(3));
            for (int j = 0; j < nw; j++)
                wr(int'($urandom_range(15)), qw(int'($urandom_range(128)) - 64));
            ca = ($urandom_range(1) == 1) ? int'($urandom_range(NS - 1)) : -1;
            run_pass("rnd", NS'($urandom), 1'b1, ca, int'($urandom_range(15)),
                     qw(int'($urandom_range(128)) - 64),
                     ($urandom_range(3) == 0) ? int'($urandom_range(1, 8)) : -1, got);
        end

        // Reset mid-pass aborts and clears everything.
        start = 1'b1; pre = '1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        clear_model();
        chk("t5 busy", 32'(busy), 32'h0);
        chk("t5 done", 32'(done), 32'h0);
        chk("t5 i_syn", isyn, 32'h0);
        count_dones(15, cnt);
        chk("t5 no_done", 32'(cnt), 32'h0);
        run_pass("t5b", '1, 1'b1, -1, 0, 0, -1, got);
        chk("t5b const", got, 32'h0);

        // Write coinciding with reset is discarded.
        wr(2, 32'h4000_0000);
        rst = 1'b1; we = 1'b1; waddr = 4'd5; wdata = 32'h4080_0000;
        tick();
        rst = 1'b0; we = 1'b0;
        clear_model();
        run_pass("t6", '1, 1'b1, -1, 0, 0, -1, got);
        chk("t6 const", got, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
